rx_stat_counter_bank: RTL and testbench

- Bank of NCH independent statistics counters for the 10G RX engine.
- Counts frames, bytes, CRC errors, runts, etc. per channel.
- Each channel increments by a variable amount per cycle, wraps or saturates per mode, and keeps a sticky overflow flag.
- Host side reads one channel at a time with optional clear-on-read; a global clear resets the whole bank.

---
 rtl/rx_stat_pkg.sv | 26 ++
 rtl/rx_stat_cell.sv | 68 ++++++
 rtl/rx_stat_counter_bank.sv | 108 ++++++++++
 tb/tb_rx_stat_counter_bank.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_stat_pkg.sv
// rx_stat_pkg
// Shared constants for the RX statistics counter bank: counting modes,
// default geometry, and the channel assignment used by the 10G RX engine.
package rx_stat_pkg;

  // Counting modes
  localparam int STAT_WRAP = 0;
  localparam int STAT_SAT  = 1;

  // Default geometry
  localparam int DEF_NCH   = 8;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_INC_W = 16;
  localparam int DEF_AW    = 3;

  // Channel assignment
  localparam int CH_FRAMES  = 0;
  localparam int CH_BYTES   = 1;
  localparam int CH_CRC_ERR = 2;
  localparam int CH_RUNT    = 3;
  localparam int CH_LONG    = 4;
  localparam int CH_PAUSE   = 5;
  localparam int CH_BCAST   = 6;
  localparam int CH_MCAST   = 7;

endpackage

// File: rtl/rx_stat_cell.sv
// rx_stat_cell
// One statistics counter with its sticky overflow flag.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   clr               bank-wide clear (highest priority)
//   clr_rd            clear-on-read of this channel
//   inc_en, inc_val   increment strobe and amount
//   cnt, ovf          current counter value and sticky overflow flag
//   ovf_nxt           overflow flag value being loaded this cycle
module rx_stat_cell
  import rx_stat_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int INC_W    = DEF_INC_W,
  parameter int SATURATE = STAT_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             clr_rd,
  input  logic             inc_en,
  input  logic [INC_W-1:0] inc_val,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf,
  output logic             ovf_nxt
);

  // Carry out of the WIDTH+1 bit sum marks an overflow; saturate mode pins
  // the counter at all-ones, wrap mode keeps the low bits.
  function automatic logic [WIDTH-1:0] wrap_or_sat(input logic [WIDTH:0] s);
    if (s[WIDTH] && (SATURATE == STAT_SAT))
      return '1;
    return s[WIDTH-1:0];
  endfunction

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] cnt_nxt;

  always_comb begin
    sum     = {1'b0, cnt} + (WIDTH+1)'(inc_val);
    cnt_nxt = cnt;
    ovf_nxt = ovf;
    if (clr) begin
      cnt_nxt = '0;
      ovf_nxt = 1'b0;
    end else if (clr_rd) begin
      // Clearing read restarts from this cycle's increment so none is lost.
      cnt_nxt = inc_en ? WIDTH'(inc_val) : '0;
      ovf_nxt = 1'b0;
    end else if (inc_en) begin
      cnt_nxt = wrap_or_sat(sum);
      if (sum[WIDTH])
        ovf_nxt = 1'b1;
    end
  end

  // ---- stage p1: counter state ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
    end
  end

endmodule

// File: rtl/rx_stat_counter_bank.sv
// rx_stat_counter_bank
// Bank of NCH independent statistics counters with a single-channel host
// read port (1-cycle latency, optional clear-on-read) and a global clear.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   clr_all           synchronous clear of all counters and flags
//   inc_en, inc_val   per-channel increment strobe / amount (INC_W each)
//   rd_req, rd_addr   read request and channel address
//   rd_clr            clear the addressed channel after sampling
//   rd_valid          one-cycle pulse, cycle after rd_req
//   rd_data, rd_ovf   sampled counter value and overflow flag
//   ovf_any           registered OR of all overflow flags
module rx_stat_counter_bank
  import rx_stat_pkg::*;
#(
  parameter int NCH      = DEF_NCH,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int INC_W    = DEF_INC_W,
  parameter int SATURATE = STAT_WRAP,
  parameter int AW       = DEF_AW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_all,
  input  logic [NCH-1:0]       inc_en,
  input  logic [NCH*INC_W-1:0] inc_val,
  input  logic                 rd_req,
  input  logic [AW-1:0]        rd_addr,
  input  logic                 rd_clr,
  output logic                 rd_valid,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_ovf,
  output logic                 ovf_any
);

  if (INC_W > WIDTH) begin : g_chk_inc_w
    $error("rx_stat_counter_bank: INC_W must not exceed WIDTH");
  end
  if ((NCH < 1) || (NCH > 32) || ((1 << AW) < NCH)) begin : g_chk_geom
    $error("rx_stat_counter_bank: need 1 <= NCH <= 32 and 2**AW >= NCH");
  end

  logic [WIDTH-1:0] cnt [NCH];
  logic [NCH-1:0]   ovf;
  logic [NCH-1:0]   ovf_nxt;

  for (genvar g = 0; g < NCH; g++) begin : g_cell
    rx_stat_cell #(
      .WIDTH    (WIDTH),
      .INC_W    (INC_W),
      .SATURATE (SATURATE)
    ) u_cell (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr_all),
      .clr_rd  (rd_req & rd_clr & (rd_addr == AW'(g))),
      .inc_en  (inc_en[g]),
      .inc_val (inc_val[g*INC_W +: INC_W]),
      .cnt     (cnt[g]),
      .ovf     (ovf[g]),
      .ovf_nxt (ovf_nxt[g])
    );
  end

  // ---- stage p0: read select from pre-update state ----
  // Addresses at or beyond NCH match no channel and therefore read zero.
  logic [WIDTH-1:0] rd_data_p0;
  logic             rd_ovf_p0;

  always_comb begin
    rd_data_p0 = '0;
    rd_ovf_p0  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_addr == AW'(i)) begin
        rd_data_p0 = cnt[i];
        rd_ovf_p0  = ovf[i];
      end
    end
  end

  // ---- stage p1: registered read port and overflow summary ----
  logic             vld_p1;
  logic [WIDTH-1:0] rd_data_p1;
  logic             rd_ovf_p1;
  logic             ovf_any_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      rd_data_p1 <= '0;
      rd_ovf_p1  <= 1'b0;
      ovf_any_p1 <= 1'b0;
    end else begin
      vld_p1     <= rd_req;
      ovf_any_p1 <= |ovf_nxt;
      if (rd_req) begin
        rd_data_p1 <= rd_data_p0;
        rd_ovf_p1  <= rd_ovf_p0;
      end
    end
  end

  assign rd_valid = vld_p1;
  assign rd_data  = rd_data_p1;
  assign rd_ovf   = rd_ovf_p1;
  assign ovf_any  = ovf_any_p1;

endmodule

// File: tb/tb_rx_stat_counter_bank.sv
// tb_rx_stat_counter_bank
// Drives a wrap-mode and a saturate-mode bank (WIDTH=8, NCH=8, AW=4) with
// the same directed stimulus and checks both against a behavioural model,
// plus literal expectations at the key points of each scenario.
module tb_rx_stat_counter_bank;
  localparam int NCH   = 8;
  localparam int WIDTH = 8;
  localparam int INC_W = 8;
  localparam int AW    = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 clr_all = 1'b0;
  logic [NCH-1:0]       inc_en = '0;
  logic [NCH*INC_W-1:0] inc_val = '0;
  logic                 rd_req = 1'b0;
  logic [AW-1:0]        rd_addr = '0;
  logic                 rd_clr = 1'b0;

  logic             w_valid, w_ovf, w_any, s_valid, s_ovf, s_any;
  logic [WIDTH-1:0] w_data, s_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rx_stat_counter_bank #(.NCH(NCH), .WIDTH(WIDTH), .INC_W(INC_W), .SATURATE(0), .AW(AW)) u_wrap (
    .clk(clk), .reset(reset), .clr_all(clr_all), .inc_en(inc_en), .inc_val(inc_val),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_clr(rd_clr),
    .rd_valid(w_valid), .rd_data(w_data), .rd_ovf(w_ovf), .ovf_any(w_any));

  rx_stat_counter_bank #(.NCH(NCH), .WIDTH(WIDTH), .INC_W(INC_W), .SATURATE(1), .AW(AW)) u_sat (
    .clk(clk), .reset(reset), .clr_all(clr_all), .inc_en(inc_en), .inc_val(inc_val),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_clr(rd_clr),
    .rd_valid(s_valid), .rd_data(s_data), .rd_ovf(s_ovf), .ovf_any(s_any));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: index 0 = wrap bank, index 1 = saturate bank.
  int m_cnt [2][NCH];
  bit m_ovf [2][NCH];
  bit e_valid = 1'b0;
  int e_data [2];
  bit e_ovf  [2];
  bit e_any  [2];
  int v, inc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid = 1'b0;
      for (int m = 0; m < 2; m++) begin
        e_data[m] = 0; e_ovf[m] = 1'b0; e_any[m] = 1'b0;
        for (int i = 0; i < NCH; i++) begin m_cnt[m][i] = 0; m_ovf[m][i] = 1'b0; end
      end
    end else begin
      e_valid = rd_req;
      for (int m = 0; m < 2; m++) begin
        if (rd_req) begin
          e_data[m] = (rd_addr < NCH) ? m_cnt[m][rd_addr] : 0;
          e_ovf[m]  = (rd_addr < NCH) ? m_ovf[m][rd_addr] : 1'b0;
        end
        e_any[m] = 1'b0;
        for (int i = 0; i < NCH; i++) begin
          if (clr_all) begin
            m_cnt[m][i] = 0;
            m_ovf[m][i] = 1'b0;
          end else begin
            v = m_cnt[m][i];
            if (rd_req && rd_clr && (rd_addr == i)) begin v = 0; m_ovf[m][i] = 1'b0; end
            if (inc_en[i]) begin
              inc = int'(inc_val[i*INC_W +: INC_W]);
              v = v + inc;
              if (v > MAXV) begin
                m_ovf[m][i] = 1'b1;
                v = (m == 1) ? MAXV : v - (MAXV + 1);
              end
            end
            m_cnt[m][i] = v;
          end
          e_any[m] = e_any[m] | m_ovf[m][i];
        end
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    chk("w_rd_valid", w_valid, e_valid);
    chk("s_rd_valid", s_valid, e_valid);
    if (e_valid) begin
      chk("w_rd_data", w_data, e_data[0]);
      chk("s_rd_data", s_data, e_data[1]);
      chk("w_rd_ovf", w_ovf, e_ovf[0]);
      chk("s_rd_ovf", s_ovf, e_ovf[1]);
    end
    chk("w_ovf_any", w_any, e_any[0]);
    chk("s_ovf_any", s_any, e_any[1]);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet();
    inc_en = '0; inc_val = '0; rd_req = 1'b0; rd_clr = 1'b0; clr_all = 1'b0; rd_addr = '0;
  endtask

  task automatic inc1(input int ch, input int val);
    quiet();
    inc_en[ch] = 1'b1;
    inc_val[ch*INC_W +: INC_W] = INC_W'(val);
    step();
  endtask

  task automatic rd(input int ch, input bit clr);
    quiet();
    rd_req = 1'b1; rd_addr = AW'(ch); rd_clr = clr;
    step();
    quiet();
  endtask

  initial begin
    quiet();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state read
    rd(0, 0);
    chk("lit_reset_valid", w_valid, 1);
    chk("lit_reset_data", w_data, 0);
    chk("lit_reset_ovf", w_ovf, 0);
    chk("lit_reset_any", w_any, 0);

    // Two increments of 200 on channel 2
    inc1(2, 200);
    chk("lit_any_no_carry", w_any, 0);
    inc1(2, 200);
    chk("lit_w_any_after_carry", w_any, 1);
    chk("lit_s_any_after_carry", s_any, 1);
    rd(2, 0);
    chk("lit_w_ch2_data", w_data, 144);
    chk("lit_w_ch2_ovf", w_ovf, 1);
    chk("lit_s_ch2_data", s_data, 255);
    rd(2, 1);
    chk("lit_w_ch2_clrrd_data", w_data, 144);
    chk("lit_w_ch2_clrrd_ovf", w_ovf, 1);
    rd(2, 0);
    chk("lit_w_ch2_after_clr", w_data, 0);
    chk("lit_w_ch2_ovf_after_clr", w_ovf, 0);
    chk("lit_w_any_after_clr", w_any, 0);

    // Saturation on channel 4: 250, 10, then 1
    inc1(4, 250);
    inc1(4, 10);
    inc1(4, 1);
    rd(4, 0);
    chk("lit_s_ch4_data", s_data, 255);
    chk("lit_s_ch4_ovf", s_ovf, 1);
    chk("lit_w_ch4_data", w_data, 5);

    // Clear-on-read colliding with an increment on channel 1
    inc1(1, 7);
    quiet();
    rd_req = 1'b1; rd_addr = AW'(1); rd_clr = 1'b1;
    inc_en[1] = 1'b1; inc_val[1*INC_W +: INC_W] = 8'd5;
    step();
    chk("lit_ch1_sampled", w_data, 7);
    rd(1, 0);
    chk("lit_ch1_after", s_data, 5);
    chk("lit_ch1_ovf_after", s_ovf, 0);

    // clr_all against increments everywhere and a read of channel 3
    inc1(3, 9);
    chk("lit_any_before_clr_all", s_any, 1);
    quiet();
    clr_all = 1'b1; inc_en = '1; inc_val = {NCH{8'd3}};
    rd_req = 1'b1; rd_addr = AW'(3);
    step();
    chk("lit_clr_all_read", w_data, 9);
    chk("lit_clr_all_any", w_any, 0);
    quiet();
    for (int ch = 0; ch < NCH; ch++) begin
      rd_req = 1'b1; rd_addr = AW'(ch);
      step();
      chk("lit_cleared_w", w_data, 0);
      chk("lit_cleared_s", s_data, 0);
    end
    quiet();

    // Out-of-range address, with rd_clr, must not touch channel 5
    inc1(5, 17);
    rd(NCH, 1);
    chk("lit_oor_valid", w_valid, 1);
    chk("lit_oor_data", w_data, 0);
    chk("lit_oor_ovf", w_ovf, 0);
    rd(5, 0);
    chk("lit_ch5_kept", w_data, 17);

    // Back-to-back reads interrupted by an asynchronous reset
    inc1(6, 33);
    quiet();
    for (int k = 0; k < 3; k++) begin
      rd_req = 1'b1; rd_addr = AW'(6 + (k % 2));
      step();
    end
    @(posedge clk);
    #1;
    chk("lit_valid_before_reset", w_valid, 1);
    #1 reset = 1'b1;
    #1;
    chk("lit_w_valid_in_reset", w_valid, 0);
    chk("lit_s_valid_in_reset", s_valid, 0);
    chk("lit_data_in_reset", w_data, 0);
    @(negedge clk);
    quiet();
    @(negedge clk);
    reset = 1'b0;
    rd(6, 0);
    chk("lit_ch6_after_reset", w_data, 0);
    rd(NCH, 0);
    chk("lit_oor_after_reset_valid", s_valid, 1);
    chk("lit_oor_after_reset_data", s_data, 0);

    quiet();
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
